// File: rtl/ks_data_path_gen2_if.sv
// Control/memory-side bus of the K&S gen2 datapath: control-unit strobes in,
// memory address/data and status flags out.
interface ks_data_path_gen2_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              stall;
    logic              ir_enable;
    logic              pc_enable;
    logic              branch;
    logic              addr_sel;
    logic              c_sel;
    logic [1:0]        operation;
    logic              write_reg_enable;
    logic              flags_reg_enable;
    logic [DATA_W-1:0] data_in;
    logic              illegal_instr;
    logic              zero_op;
    logic              neg_op;
    logic              unsigned_overflow;
    logic              signed_overflow;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] data_out;

    modport master (
        output stall, ir_enable, pc_enable, branch, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, data_in,
        input  illegal_instr, zero_op, neg_op, unsigned_overflow, signed_overflow,
               ram_addr, data_out
    );

    modport slave (
        input  stall, ir_enable, pc_enable, branch, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, data_in,
        output illegal_instr, zero_op, neg_op, unsigned_overflow, signed_overflow,
               ram_addr, data_out
    );
endinterface

// File: rtl/ks_data_path_gen2.sv
// K&S gen2 datapath: IR, register bank, flag-generating ALU, PC and address mux,
// sequenced by the K&S control unit; stall freezes every piece of state.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_HALT
    } decoded_instruction_type;
endpackage

module ks_data_path_gen2
    import k_and_s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ks_data_path_gen2_if.slave      dp,
    output decoded_instruction_type decoded_instruction
);
    localparam int RA_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              zero_q, zero_d, neg_q, neg_d;
    logic              uovf_q, uovf_d, sovf_q, sovf_d;

    logic [7:0]        opcode_s;
    logic [RA_W-1:0]   c_idx_s, a_idx_s, b_idx_s;
    logic [ADDR_W-1:0] mem_field_s;
    logic [DATA_W-1:0] bus_a_s, bus_b_s, bus_c_s, alu_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic              alu_uovf_s, alu_sovf_s, illegal_s, unused_ir_s;

    assign opcode_s    = ir_q[DATA_W-1 -: 8];
    assign c_idx_s     = ir_q[3*RA_W-1 -: RA_W];
    assign a_idx_s     = ir_q[2*RA_W-1 -: RA_W];
    assign b_idx_s     = ir_q[RA_W-1:0];
    assign mem_field_s = ir_q[ADDR_W-1:0];
    assign unused_ir_s = ^ir_q;

    // Reads see pre-write register contents: no write-to-read bypass.
    assign bus_a_s = regs_q[a_idx_s];
    assign bus_b_s = regs_q[b_idx_s];
    assign sum_s   = {1'b0, bus_a_s} + {1'b0, bus_b_s};
    assign diff_s  = {1'b0, bus_a_s} - {1'b0, bus_b_s};
    assign bus_c_s = dp.c_sel ? dp.data_in : alu_s;

    // ALU result and overflow flags; the extra top bit of diff is the borrow.
    always_comb begin
        alu_s      = {DATA_W{1'b0}};
        alu_uovf_s = 1'b0;
        alu_sovf_s = 1'b0;
        case (dp.operation)
            2'b00: begin
                alu_s      = sum_s[DATA_W-1:0];
                alu_uovf_s = sum_s[DATA_W];
                alu_sovf_s = (bus_a_s[DATA_W-1] == bus_b_s[DATA_W-1]) &&
                             (sum_s[DATA_W-1] != bus_a_s[DATA_W-1]);
            end
            2'b01: begin
                alu_s      = diff_s[DATA_W-1:0];
                alu_uovf_s = diff_s[DATA_W];
                alu_sovf_s = (bus_a_s[DATA_W-1] != bus_b_s[DATA_W-1]) &&
                             (diff_s[DATA_W-1] != bus_a_s[DATA_W-1]);
            end
            2'b10:   alu_s = bus_a_s & bus_b_s;
            2'b11:   alu_s = bus_a_s | bus_b_s;
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // Opcode decode straight from the IR.
    always_comb begin
        decoded_instruction = I_NOP;
        illegal_s           = 1'b0;
        case (opcode_s)
            8'h00:   decoded_instruction = I_NOP;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h0B:   decoded_instruction = I_BNZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h0A:   decoded_instruction = I_BNNEG;
            8'hFF:   decoded_instruction = I_HALT;
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state selection; stall holds everything.
    always_comb begin
        ir_d   = ir_q;
        regs_d = regs_q;
        pc_d   = pc_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        uovf_d = uovf_q;
        sovf_d = sovf_q;
        if (!dp.stall && dp.ir_enable) begin
            ir_d = dp.data_in;
        end else begin
            ir_d = ir_q;
        end
        if (!dp.stall && dp.write_reg_enable) begin
            regs_d[c_idx_s] = bus_c_s;
        end else begin
            regs_d = regs_q;
        end
        if (!dp.stall && dp.flags_reg_enable) begin
            zero_d = (alu_s == {DATA_W{1'b0}});
            neg_d  = alu_s[DATA_W-1];
            uovf_d = alu_uovf_s;
            sovf_d = alu_sovf_s;
        end else begin
            zero_d = zero_q;
            neg_d  = neg_q;
        end
        if (dp.stall) begin
            pc_d = pc_q;
        end else if (dp.pc_enable && dp.branch) begin
            pc_d = mem_field_s;
        end else if (dp.pc_enable) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q   <= {DATA_W{1'b0}};
            pc_q   <= {ADDR_W{1'b0}};
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uovf_q <= 1'b0;
            sovf_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            ir_q   <= ir_d;
            pc_q   <= pc_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            uovf_q <= uovf_d;
            sovf_q <= sovf_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign dp.illegal_instr     = illegal_s;
    assign dp.zero_op           = zero_q;
    assign dp.neg_op            = neg_q;
    assign dp.unsigned_overflow = uovf_q;
    assign dp.signed_overflow   = sovf_q;
    assign dp.ram_addr          = dp.addr_sel ? mem_field_s : pc_q;
    assign dp.data_out          = bus_a_s;
endmodule

// File: tb/tb_ks_data_path_gen2.sv
// Bench for ks_data_path_gen2: directed scenarios plus random control sequences,
// all compared against an arithmetic reference model of the datapath.
module tb_ks_data_path_gen2;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    decoded_instruction_type decoded_s;
    int n_checks = 0;
    int n_errors = 0;

    ks_data_path_gen2_if #(.DATA_W(16), .ADDR_W(5)) dp_if ();
    ks_data_path_gen2 #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(5)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dp                  (dp_if),
        .decoded_instruction (decoded_s)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [15:0] m_ir;
    logic [15:0] m_regs [4];
    int          m_pc;
    logic        m_z, m_n, m_u, m_s;
    bit          m_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic void alu_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic u, output logic s);
        int ua = int'(a);
        int ub = int'(b);
        int sr;
        r = 16'h0; u = 1'b0; s = 1'b0;
        case (op)
            2'b00: begin
                r  = 16'((ua + ub) % 65536);
                u  = (ua + ub) > 65535;
                sr = sx(a) + sx(b);
                s  = (sr > 32767) || (sr < -32768);
            end
            2'b01: begin
                r  = 16'((ua - ub + 65536) % 65536);
                u  = ua < ub;
                sr = sx(a) - sx(b);
                s  = (sr > 32767) || (sr < -32768);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
    endfunction

    function automatic decoded_instruction_type exp_decode(input logic [7:0] opc, output logic ill);
        ill = 1'b0;
        case (opc)
            8'h00: return I_NOP;
            8'h81: return I_LOAD;
            8'h82: return I_STORE;
            8'h91: return I_MOVE;
            8'hA1: return I_ADD;
            8'hA2: return I_SUB;
            8'hA3: return I_AND;
            8'hA4: return I_OR;
            8'h01: return I_BRANCH;
            8'h02: return I_BZERO;
            8'h0B: return I_BNZERO;
            8'h03: return I_BNEG;
            8'h0A: return I_BNNEG;
            8'hFF: return I_HALT;
            default: begin
                ill = 1'b1;
                return I_NOP;
            end
        endcase
    endfunction

    // One clock: drive, check same-cycle outputs against the model, then advance model.
    task automatic cycle(input logic rst, input logic st, input logic ire, input logic pce,
                         input logic br, input logic asel, input logic csel, input logic [1:0] op,
                         input logic wre, input logic fre, input logic [15:0] din);
        logic [15:0] av, bv, r;
        logic u, s, ill;
        decoded_instruction_type ed;
        rst_n = rst;
        dp_if.stall = st; dp_if.ir_enable = ire; dp_if.pc_enable = pce; dp_if.branch = br;
        dp_if.addr_sel = asel; dp_if.c_sel = csel; dp_if.operation = op;
        dp_if.write_reg_enable = wre; dp_if.flags_reg_enable = fre; dp_if.data_in = din;
        #1;
        av = m_regs[m_ir[3:2]];
        bv = m_regs[m_ir[1:0]];
        alu_model(op, av, bv, r, u, s);
        if (m_valid) begin
            ed = exp_decode(m_ir[15:8], ill);
            check_eq("decode", 32'(decoded_s), 32'(ed));
            check_eq("illegal", 32'(dp_if.illegal_instr), 32'(ill));
            check_eq("ram_addr", 32'(dp_if.ram_addr), asel ? 32'(m_ir[4:0]) : 32'(m_pc));
            check_eq("data_out", 32'(dp_if.data_out), 32'(av));
            check_eq("flags", {28'h0, dp_if.zero_op, dp_if.neg_op, dp_if.unsigned_overflow,
                     dp_if.signed_overflow}, {28'h0, m_z, m_n, m_u, m_s});
        end
        @(posedge clk);
        if (!rst) begin
            m_ir = 16'h0; m_pc = 0; m_z = 1'b0; m_n = 1'b0; m_u = 1'b0; m_s = 1'b0;
            for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
            m_valid = 1'b1;
        end else if (!st) begin
            if (pce) m_pc = br ? int'(m_ir[4:0]) : (m_pc + 1) % 32;
            if (wre) m_regs[m_ir[5:4]] = csel ? din : r;
            if (fre) begin
                m_z = (r == 16'h0); m_n = r[15]; m_u = u; m_s = s;
            end
            if (ire) m_ir = din;
        end
        #1;
    endtask

    task automatic load_ir(input logic [15:0] v);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, v);
    endtask

    task automatic load_reg(input logic [1:0] c, input logic [15:0] v);
        load_ir({8'h81, 2'b00, c, 4'h0});
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, v);
    endtask

    task automatic alu_op(input logic [15:0] ir, input logic [1:0] op);
        load_ir(ir);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b1, 1'b1, 16'h0);
    endtask

    logic [7:0] ops [15] = '{8'h00, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                             8'h01, 8'h02, 8'h0B, 8'h03, 8'h0A, 8'hFF, 8'h55};

    initial begin
        // Reset dominates stall and every enable.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 16'hFFFF);
        check_eq("rst_ram_addr", 32'(dp_if.ram_addr), 32'h0);
        check_eq("rst_data_out", 32'(dp_if.data_out), 32'h0);
        check_eq("rst_decode", 32'(decoded_s), 32'(I_NOP));
        check_eq("rst_illegal", 32'(dp_if.illegal_instr), 32'h0);
        check_eq("rst_flags", {28'h0, dp_if.zero_op, dp_if.neg_op, dp_if.unsigned_overflow,
                 dp_if.signed_overflow}, 32'h0);

        load_reg(2'd1, 16'h7FFF);
        load_reg(2'd2, 16'h0001);
        alu_op(16'hA106, 2'b00);
        check_eq("add_flags", {28'h0, dp_if.zero_op, dp_if.neg_op, dp_if.unsigned_overflow,
                 dp_if.signed_overflow}, 32'b0101);
        load_ir(16'h8200);
        check_eq("add_r0", 32'(dp_if.data_out), 32'h8000);

        load_reg(2'd1, 16'h0000);
        alu_op(16'hA206, 2'b01);
        check_eq("sub_borrow_flags", {28'h0, dp_if.zero_op, dp_if.neg_op, dp_if.unsigned_overflow,
                 dp_if.signed_overflow}, 32'b0110);
        load_ir(16'h8200);
        check_eq("sub_r0", 32'(dp_if.data_out), 32'hFFFF);
        load_reg(2'd1, 16'h0005);
        load_reg(2'd2, 16'h0005);
        alu_op(16'hA206, 2'b01);
        check_eq("sub_zero_flags", {28'h0, dp_if.zero_op, dp_if.neg_op, dp_if.unsigned_overflow,
                 dp_if.signed_overflow}, 32'b1000);

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 31; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        check_eq("pc_31", 32'(dp_if.ram_addr), 32'd31);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        check_eq("pc_wrap", 32'(dp_if.ram_addr), 32'd0);
        load_ir(16'h0113);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        check_eq("pc_branch", 32'(dp_if.ram_addr), 32'h13);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        check_eq("pc_branch_no_en", 32'(dp_if.ram_addr), 32'h13);

        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'h8110);
        check_eq("stall_pc", 32'(dp_if.ram_addr), 32'h13);
        check_eq("stall_ir", 32'(decoded_s), 32'(I_BRANCH));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'h8110);
        check_eq("resume_pc", 32'(dp_if.ram_addr), 32'h14);
        check_eq("resume_ir", 32'(decoded_s), 32'(I_LOAD));

        load_ir(16'h5500);
        check_eq("illegal_flag", 32'(dp_if.illegal_instr), 32'h1);
        check_eq("illegal_decode", 32'(decoded_s), 32'(I_NOP));
        load_ir(16'hFF00);
        check_eq("halt_decode", 32'(decoded_s), 32'(I_HALT));
        check_eq("halt_illegal", 32'(dp_if.illegal_instr), 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] din;
            logic ire;
            ire = ($urandom_range(0, 3) == 0);
            din = ire ? {ops[$urandom_range(0, 14)], 8'($urandom)} : 16'($urandom);
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) == 0), ire,
                  ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom), din);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
